// File: rtl/vector_list_sequencer.sv
// Vector display-list sequencer: fetches 18-bit words and drives X/Y DACs + beam.
// Ports: clk/rst_n, start/stop/loop_en/base_addr, rd_en/rd_addr/rd_data, x/y/beam/busy/frame_done.
module vector_list_sequencer #(
  parameter int ADDRESSWIDTH = 16,
  parameter int DATAWIDTH    = 18,
  parameter int OUT_WIDTH    = 8,
  parameter int CEASE_CYCLES = 2,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    loop_en,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] rd_addr,
  input  logic [DATAWIDTH-1:0]    rd_data,
  output logic [OUT_WIDTH-1:0]    x_out,
  output logic [OUT_WIDTH-1:0]    y_out,
  output logic                    beam_en,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int MAXC = (CEASE_CYCLES > DWELL_CYCLES)
                      ? CEASE_CYCLES : DWELL_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAW,
    S_MOVE,
    S_ENDF
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]    x_d, y_d;
  logic [1:0]              op;
  logic [OUT_WIDTH-1:0]    wx, wy;

  assign op      = rd_data[DATAWIDTH-1 -: 2];
  assign wx      = rd_data[2*OUT_WIDTH-1:OUT_WIDTH];
  assign wy      = rd_data[OUT_WIDTH-1:0];
  assign rd_addr = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    x_d     = x_out;
    y_d     = y_out;
    if (stop && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            addr_d  = base_addr;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          unique case (op)
            2'b00: begin
              x_d     = wx;
              y_d     = wy;
              addr_d  = addr_q + ADDRESSWIDTH'(1);
              cnt_d   = CW'(DWELL_CYCLES - 1);
              state_d = S_DRAW;
            end
            2'b01: begin
              x_d     = wx;
              y_d     = wy;
              addr_d  = addr_q + ADDRESSWIDTH'(1);
              cnt_d   = CW'(CEASE_CYCLES - 1);
              state_d = S_MOVE;
            end
            2'b10: state_d = S_ENDF;
            2'b11: begin
              addr_d  = addr_q + ADDRESSWIDTH'(1);
              state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
          endcase
        end
        S_DRAW, S_MOVE: begin
          if (cnt_q == '0) state_d = S_FETCH;
          else             cnt_d   = cnt_q - CW'(1);
        end
        S_ENDF: begin
          if (loop_en) begin
            addr_d  = base_addr;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      x_out      <= '0;
      y_out      <= '0;
      rd_en      <= 1'b0;
      beam_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      x_out      <= x_d;
      y_out      <= y_d;
      rd_en      <= (state_d == S_FETCH);
      beam_en    <= (state_d == S_DRAW);
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_d == S_ENDF);
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Scoreboard bench for vector_list_sequencer with a list-walking reference model.
// Expected per-busy-cycle outputs are queued; a negedge monitor pops and compares.
module tb_vector_list_sequencer;

  localparam int DWELL = 4;
  localparam int CEASE = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [15:0] base_addr;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [17:0] rd_data;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic        beam_en;
  logic        busy;
  logic        frame_done;

  vector_list_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .base_addr  (base_addr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .beam_en    (beam_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [17:0] mem [0:65535];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  typedef struct packed {
    logic        rd;
    logic [15:0] ra;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        beam;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  obs_t tr[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] mx = 8'd0;
  logic [7:0] my = 8'd0;
  logic [7:0] lx = 8'd0;
  logic [7:0] ly = 8'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic obs_t mk(input logic rd, input logic [15:0] ra,
                              input logic [7:0] x, input logic [7:0] y,
                              input logic beam, input logic done);
    obs_t o;
    o.rd = rd; o.ra = ra; o.x = x; o.y = y;
    o.beam = beam; o.done = done;
    return o;
  endfunction

  // Monitor: every busy cycle must match the next expected entry;
  // idle cycles must show no strobes and held coordinates.
  always @(negedge clk) begin
    obs_t e;
    if (!rst_n) begin
      lx = 8'd0;
      ly = 8'd0;
    end else if (busy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_busy actual=busy required=idle");
      end else begin
        e = exp_q.pop_front();
        if (rd_en !== e.rd || (e.rd && rd_addr !== e.ra) ||
            x_out !== e.x || y_out !== e.y ||
            beam_en !== e.beam || frame_done !== e.done) begin
          failures++;
          $display("FAIL cycle actual=rd%b a%h x%h y%h b%b d%b required=rd%b a%h x%h y%h b%b d%b",
                   rd_en, rd_addr, x_out, y_out, beam_en, frame_done,
                   e.rd, e.ra, e.x, e.y, e.beam, e.done);
        end
        lx = e.x;
        ly = e.y;
      end
    end else begin
      checks++;
      if (rd_en || beam_en || frame_done ||
          x_out !== lx || y_out !== ly) begin
        failures++;
        $display("FAIL idle actual=rd%b b%b d%b x%h y%h required=rd0 b0 d0 x%h y%h",
                 rd_en, beam_en, frame_done, x_out, y_out, lx, ly);
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [1:0] op,
                    input logic [7:0] x, input logic [7:0] y);
    mem[a] = {op, x, y};
  endtask

  // Reference walk of the list: one entry per busy cycle.
  task automatic build(input logic [15:0] base, input bit lp,
                       input int stop_at);
    logic [15:0] a;
    logic [7:0]  cx, cy;
    logic [17:0] w;
    bit          fin;
    tr.delete();
    cx = mx; cy = my; fin = 0;
    while (!fin) begin
      a = base;
      for (int g = 0; g < 300; g++) begin
        tr.push_back(mk(1'b1, a, cx, cy, 1'b0, 1'b0));
        w = mem[a];
        tr.push_back(mk(1'b0, a, cx, cy, 1'b0, 1'b0));
        if (w[17:16] == 2'b10) begin
          tr.push_back(mk(1'b0, a, cx, cy, 1'b0, 1'b1));
          break;
        end
        a = a + 16'd1;
        if (w[17:16] != 2'b11) begin
          cx = w[15:8];
          cy = w[7:0];
          if (w[17:16] == 2'b00)
            repeat (DWELL) tr.push_back(mk(1'b0, a, cx, cy, 1'b1, 1'b0));
          else
            repeat (CEASE) tr.push_back(mk(1'b0, a, cx, cy, 1'b0, 1'b0));
        end
      end
      if (!lp || stop_at < 0 || tr.size() > stop_at) fin = 1;
    end
    if (stop_at >= 0)
      while (tr.size() > stop_at + 1) void'(tr.pop_back());
  endtask

  task automatic push_trace();
    foreach (tr[i]) exp_q.push_back(tr[i]);
    if (tr.size() > 0) begin
      mx = tr[tr.size()-1].x;
      my = tr[tr.size()-1].y;
    end
  endtask

  task automatic drive(input logic [15:0] base, input bit lp,
                       input int stop_at, input int restart_at);
    int i;
    bit fin;
    @(negedge clk);
    base_addr = base; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0; fin = 0;
    while (!fin) begin
      if (i == restart_at) begin
        start = 1'b1; base_addr = ~base;
      end else if (i == restart_at + 1) begin
        start = 1'b0; base_addr = base;
      end
      if (i == stop_at) stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      i++;
      if (!busy) fin = 1;
      else if (i > 2000) begin
        chk("busy_timeout", 32'(busy), 32'd0);
        fin = 1;
      end
    end
    start = 1'b0; loop_en = 1'b0; base_addr = base;
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run(input logic [15:0] base, input bit lp,
                     input int stop_at, input int restart_at);
    build(base, lp, stop_at);
    push_trace();
    drive(base, lp, stop_at, restart_at);
  endtask

  initial begin
    logic [15:0] b;
    int n, sa;
    bit lp;
    for (int i = 0; i < 65536; i++) mem[i] = 18'h20000;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    loop_en = 1'b0; base_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_beam", 32'(beam_en), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_xy", {x_out, y_out}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    wr(16'h0010, 2'b01, 8'd10, 8'd20);
    wr(16'h0011, 2'b00, 8'd200, 8'd20);
    wr(16'h0012, 2'b10, 8'd0, 8'd0);
    run(16'h0010, 0, -1, -1);

    wr(16'h0040, 2'b11, 8'd0, 8'd0);
    wr(16'h0041, 2'b00, 8'd5, 8'd6);
    wr(16'h0042, 2'b10, 8'd0, 8'd0);
    run(16'h0040, 0, -1, -1);

    wr(16'h0080, 2'b00, 8'd1, 8'd1);
    wr(16'h0081, 2'b10, 8'd0, 8'd0);
    run(16'h0080, 1, 30, -1);

    wr(16'hFFFF, 2'b01, 8'd0, 8'd0);
    wr(16'h0000, 2'b10, 8'd0, 8'd0);
    run(16'hFFFF, 0, -1, -1);

    wr(16'h0200, 2'b10, 8'd0, 8'd0);
    run(16'h0200, 0, -1, -1);

    wr(16'h0300, 2'b00, 8'd77, 8'd88);
    wr(16'h0301, 2'b10, 8'd0, 8'd0);
    run(16'h0300, 0, 3, -1);
    run(16'h0300, 0, -1, -1);

    @(negedge clk);
    base_addr = 16'h0010; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_stop_idle", 32'(busy), 0);

    wr(16'h0400, 2'b01, 8'd3, 8'd4);
    wr(16'h0401, 2'b00, 8'd33, 8'd44);
    wr(16'h0402, 2'b10, 8'd0, 8'd0);
    run(16'h0400, 0, -1, 1);

    for (int t = 0; t < 20; t++) begin
      b = 16'($urandom_range(0, 65535));
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        logic [1:0] op;
        op = 2'($urandom_range(0, 2));
        if (op == 2'b10) op = 2'b11;
        wr(b + 16'(k), op, 8'($urandom), 8'($urandom));
      end
      wr(b + 16'(n), 2'b10, 8'd0, 8'd0);
      lp = ($urandom_range(0, 2) == 0);
      if (lp) begin
        sa = $urandom_range(5, 60);
      end else begin
        build(b, 0, -1);
        sa = ($urandom_range(0, 1) == 0) ? -1 :
             $urandom_range(0, tr.size() - 1);
      end
      run(b, lp, sa, -1);
    end

    wr(16'h0500, 2'b00, 8'd9, 8'd9);
    wr(16'h0501, 2'b10, 8'd0, 8'd0);
    build(16'h0500, 0, -1);
    push_trace();
    @(negedge clk);
    base_addr = 16'h0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_beam", 32'(beam_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_beam", 32'(beam_en), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_x", 32'(x_out), 0);
    exp_q.delete();
    mx = 8'd0; my = 8'd0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    run(16'h0500, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
